// File: rtl/mshr_hazard_tracker.sv
// rtl/mshr_hazard_tracker.sv - icache MSHR set/way dependency matrix with per-entry readiness
module mshr_hazard_tracker #(
    parameter int ENTRY_NUM   = 8,
    parameter int ENTRY_IDX_W = $clog2(ENTRY_NUM),
    parameter int SET_IDX_W   = 7,
    parameter int WAY_NUM     = 4,
    parameter int WAY_IDX_W   = $clog2(WAY_NUM),
    parameter int SET_ONLY    = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             alloc_vld_i,
    input  logic [ENTRY_IDX_W-1:0]           alloc_idx_i,
    input  logic [SET_IDX_W-1:0]             alloc_set_i,
    input  logic [WAY_IDX_W-1:0]             alloc_way_i,
    input  logic                             rel_vld_i,
    input  logic [ENTRY_IDX_W-1:0]           rel_idx_i,
    output logic                             alloc_hazard_o,
    output logic [ENTRY_NUM-1:0]             entry_busy_o,
    output logic [ENTRY_NUM-1:0]             entry_ready_o,
    output logic [ENTRY_NUM*ENTRY_NUM-1:0]   dep_matrix_o,
    output logic                             err_pulse_o
);

    localparam bit SetOnly = (SET_ONLY != 0);

    logic [ENTRY_NUM-1:0]                   busy_q, busy_d;
    logic [ENTRY_NUM-1:0][SET_IDX_W-1:0]    set_q;
    logic [ENTRY_NUM-1:0][WAY_IDX_W-1:0]    way_q;
    logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0]    row_q, row_d;
    logic                                   err_q, err_d;
    logic [ENTRY_NUM-1:0]                   match;
    logic                                   same_idx;

    assign same_idx = rel_vld_i && (rel_idx_i == alloc_idx_i);

    // A retiring entry is never a dependency of the request allocated beside it.
    always_comb begin
        match = '0;
        for (int j = 0; j < ENTRY_NUM; j++) begin
            match[j] = busy_q[j]
                    && (set_q[j] == alloc_set_i)
                    && (SetOnly || (way_q[j] == alloc_way_i))
                    && (ENTRY_IDX_W'(j) != alloc_idx_i)
                    && !(rel_vld_i && (ENTRY_IDX_W'(j) == rel_idx_i));
        end
    end

    assign alloc_hazard_o = alloc_vld_i && (|match);

    // Release is applied first so a same-index alloc ends up owning the entry.
    always_comb begin
        busy_d = busy_q;
        row_d  = row_q;
        if (rel_vld_i) begin
            busy_d[rel_idx_i] = 1'b0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                row_d[i][rel_idx_i] = 1'b0;
            end
            row_d[rel_idx_i] = '0;
        end
        if (alloc_vld_i) begin
            busy_d[alloc_idx_i] = 1'b1;
            row_d[alloc_idx_i]  = match;
        end
    end

    assign err_d = (alloc_vld_i && busy_q[alloc_idx_i] && !same_idx)
                || (rel_vld_i && !busy_q[rel_idx_i]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            set_q  <= '0;
            way_q  <= '0;
            row_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            row_q  <= row_d;
            err_q  <= err_d;
            if (alloc_vld_i) begin
                set_q[alloc_idx_i] <= alloc_set_i;
                way_q[alloc_idx_i] <= alloc_way_i;
            end
        end
    end

    always_comb begin
        entry_ready_o = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            entry_ready_o[i] = busy_q[i] && !(|row_q[i]);
        end
    end

    assign entry_busy_o = busy_q;
    assign dep_matrix_o = row_q;
    assign err_pulse_o  = err_q;

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!err_d)
            else $warning("mshr_hazard_tracker: protocol violation (alloc to busy entry or idle release)");
        end
    end

endmodule

// File: tb/tb_mshr_hazard_tracker.sv
// tb/tb_mshr_hazard_tracker.sv - directed and randomized checks of mshr_hazard_tracker against a reference model
module tb_mshr_hazard_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_vld;
    logic [2:0]  alloc_idx;
    logic [6:0]  alloc_set;
    logic [1:0]  alloc_way;
    logic        rel_vld;
    logic [2:0]  rel_idx;
    logic        haz   [2];
    logic [7:0]  busy  [2];
    logic [7:0]  ready [2];
    logic [63:0] dep   [2];
    logic        err   [2];

    int passed = 0;
    int total  = 0;

    // reference state, index 0 = set-and-way instance, 1 = set-only instance
    bit mb [2][8];
    int ms [2][8];
    int mw [2][8];
    bit md [2][8][8];
    bit merr [2];

    always #5 clk = ~clk;

    mshr_hazard_tracker #(.SET_ONLY(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_vld_i(alloc_vld), .alloc_idx_i(alloc_idx), .alloc_set_i(alloc_set), .alloc_way_i(alloc_way),
        .rel_vld_i(rel_vld), .rel_idx_i(rel_idx),
        .alloc_hazard_o(haz[0]), .entry_busy_o(busy[0]), .entry_ready_o(ready[0]),
        .dep_matrix_o(dep[0]), .err_pulse_o(err[0])
    );

    mshr_hazard_tracker #(.SET_ONLY(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_vld_i(alloc_vld), .alloc_idx_i(alloc_idx), .alloc_set_i(alloc_set), .alloc_way_i(alloc_way),
        .rel_vld_i(rel_vld), .rel_idx_i(rel_idx),
        .alloc_hazard_o(haz[1]), .entry_busy_o(busy[1]), .entry_ready_o(ready[1]),
        .dep_matrix_o(dep[1]), .err_pulse_o(err[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] exp_busy(input int k);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[i] = mb[k][i];
        return v;
    endfunction

    function automatic logic [63:0] exp_dep(input int k);
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                v[i*8+j] = md[k][i][j];
        return v;
    endfunction

    function automatic logic [7:0] exp_ready(input int k);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) begin
            bit waits = 0;
            for (int j = 0; j < 8; j++) if (md[k][i][j]) waits = 1;
            v[i] = mb[k][i] && !waits;
        end
        return v;
    endfunction

    task automatic check_state(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s busy%0d", tag, k), busy[k], exp_busy(k));
            chk($sformatf("%s ready%0d", tag, k), ready[k], exp_ready(k));
            chk($sformatf("%s dep%0d", tag, k), dep[k], exp_dep(k));
            chk($sformatf("%s err%0d", tag, k), err[k], merr[k]);
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        alloc_vld = 0; alloc_idx = 0; alloc_set = 0; alloc_way = 0;
        rel_vld = 0; rel_idx = 0;
        for (int k = 0; k < 2; k++) begin
            merr[k] = 0;
            for (int i = 0; i < 8; i++) begin
                mb[k][i] = 0; ms[k][i] = 0; mw[k][i] = 0;
                for (int j = 0; j < 8; j++) md[k][i][j] = 0;
            end
        end
        #1;
        check_state(tag);
        chk({tag, " haz0"}, haz[0], 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic cyc(input string tag, input bit av, input int ai, input int as, input int aw,
                       input bit rv, input int ri);
        bit [7:0] m [2];
        bit e [2];
        alloc_vld = av; alloc_idx = 3'(ai); alloc_set = 7'(as); alloc_way = 2'(aw);
        rel_vld = rv; rel_idx = 3'(ri);
        #1;
        for (int k = 0; k < 2; k++) begin
            m[k] = '0;
            for (int j = 0; j < 8; j++)
                if (mb[k][j] && ms[k][j] == as && (k == 1 || mw[k][j] == aw) && j != ai && !(rv && j == ri))
                    m[k][j] = 1;
            e[k] = (av && mb[k][ai] && !(rv && ri == ai)) || (rv && !mb[k][ri]);
            chk($sformatf("%s hazard%0d", tag, k), haz[k], av && (m[k] != 0));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rv) begin
                mb[k][ri] = 0;
                for (int i = 0; i < 8; i++) md[k][i][ri] = 0;
                for (int j = 0; j < 8; j++) md[k][ri][j] = 0;
            end
            if (av) begin
                mb[k][ai] = 1; ms[k][ai] = as; mw[k][ai] = aw;
                for (int j = 0; j < 8; j++) md[k][ai][j] = m[k][j];
            end
            merr[k] = e[k];
        end
        #1;
        alloc_vld = 0; rel_vld = 0;
        check_state(tag);
    endtask

    initial begin
        int free_q[$];
        int busy_q[$];
        bit av, rv;
        int ai, ri;

        do_reset("reset");

        // 1: first allocation is immediately ready
        cyc("t1", 1, 0, 5, 1, 0, 0);
        chk("t1 busy const", busy[0], 8'h01);
        chk("t1 ready const", ready[0], 8'h01);

        // 2: same set/way dependency, cleared by release
        cyc("t2a", 1, 3, 5, 1, 0, 0);
        chk("t2 row3 const", dep[0][3*8 +: 8], 8'h01);
        chk("t2 ready3 const", ready[0][3], 1'b0);
        cyc("t2b", 0, 0, 0, 0, 1, 0);
        chk("t2 row3 clr", dep[0][3*8 +: 8], 8'h00);
        chk("t2 busy clr", busy[0], 8'h08);
        chk("t2 ready3 up", ready[0][3], 1'b1);

        // 3: way mismatch matters only with set+way matching
        do_reset("t3 reset");
        cyc("t3a", 1, 0, 5, 1, 0, 0);
        cyc("t3b", 1, 1, 5, 2, 0, 0);
        chk("t3 row1 setway", dep[0][1*8 +: 8], 8'h00);
        chk("t3 row1 setonly", dep[1][1*8 +: 8], 8'h01);

        // 4: retiring entry excluded; same-index retire+alloc is legal
        do_reset("t4 reset");
        cyc("t4a", 1, 2, 9, 0, 0, 0);
        cyc("t4b", 1, 4, 9, 0, 1, 2);
        chk("t4 row4 const", dep[0][4*8 +: 8], 8'h00);
        do_reset("t4 reset2");
        cyc("t4c", 1, 2, 9, 0, 0, 0);
        cyc("t4d", 1, 2, 9, 0, 1, 2);
        chk("t4 busy2 const", busy[0][2], 1'b1);
        chk("t4 err const", err[0], 1'b0);

        // 5: protocol errors
        do_reset("t5 reset");
        cyc("t5a", 1, 1, 0, 0, 0, 0);
        cyc("t5b", 1, 1, 0, 0, 0, 0);
        chk("t5 err alloc", err[0], 1'b1);
        cyc("t5c", 0, 0, 0, 0, 0, 0);
        chk("t5 err drop", err[0], 1'b0);
        cyc("t5d", 0, 0, 0, 0, 1, 6);
        chk("t5 err rel", err[0], 1'b1);

        // 6: chain then asynchronous reset between edges
        do_reset("t6 reset");
        cyc("t6a", 1, 0, 3, 3, 0, 0);
        cyc("t6b", 1, 1, 3, 3, 0, 0);
        cyc("t6c", 1, 2, 3, 3, 0, 0);
        chk("t6 row2 const", dep[0][2*8 +: 8], 8'h03);
        do_reset("t6 midreset");

        // randomized traffic, mostly legal, with small set/way spaces to force collisions
        repeat (400) begin
            free_q.delete(); busy_q.delete();
            for (int i = 0; i < 8; i++) if (mb[0][i]) busy_q.push_back(i); else free_q.push_back(i);
            av = ($urandom_range(0, 99) < 55);
            rv = ($urandom_range(0, 99) < 40);
            ai = $urandom_range(0, 7);
            ri = $urandom_range(0, 7);
            if ($urandom_range(0, 15) != 0) begin
                if (free_q.size() != 0) ai = free_q[$urandom_range(0, free_q.size() - 1)];
                else if (rv && busy_q.size() != 0) ai = -1;
                else av = 0;
                if (busy_q.size() != 0) ri = busy_q[$urandom_range(0, busy_q.size() - 1)];
                else rv = 0;
                if (ai < 0) ai = ri;
            end
            cyc("rand", av, ai, $urandom_range(0, 2), $urandom_range(0, 1), rv, ri);
            if ($urandom_range(0, 99) == 0) do_reset("rand reset");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
